// File: rtl/bip_loadable_program_memory_if.sv
// rtl/bip_loadable_program_memory_if.sv - fetch bus, byte load stream and load status of the BIP program memory
//
// Signals (directions as seen by the memory, the slave):
//   i_addr           in   LOG2_N_INSMEM_ADDR    fetch address
//   i_enable         in   1                     fetch enable
//   o_data           out  NB_DATA               fetched instruction (registered)
//   i_load_start     in   1                     pulse: begin a new program load
//   i_load_byte      in   NB_BYTE               load data byte
//   i_load_valid     in   1                     i_load_byte valid
//   o_load_ready     out  1                     byte accepted this cycle when valid
//   o_program_ready  out  1                     program loaded, fetch active
//   o_load_count     out  LOG2_N_INSMEM_ADDR+1  words written by last load, HALT included
//   o_overflow       out  1                     memory filled without a HALT word
interface bip_loadable_program_memory_if #(
    parameter int NB_DATA            = 16,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_BYTE            = 8
);
    logic [LOG2_N_INSMEM_ADDR-1:0] i_addr;
    logic                          i_enable;
    logic [NB_DATA-1:0]            o_data;
    logic                          i_load_start;
    logic [NB_BYTE-1:0]            i_load_byte;
    logic                          i_load_valid;
    logic                          o_load_ready;
    logic                          o_program_ready;
    logic [LOG2_N_INSMEM_ADDR:0]   o_load_count;
    logic                          o_overflow;

    modport master (
        output i_addr, i_enable, i_load_start, i_load_byte, i_load_valid,
        input  o_data, o_load_ready, o_program_ready, o_load_count, o_overflow
    );

    modport slave (
        input  i_addr, i_enable, i_load_start, i_load_byte, i_load_valid,
        output o_data, o_load_ready, o_program_ready, o_load_count, o_overflow
    );
endinterface

// File: rtl/bip_loadable_program_memory.sv
// rtl/bip_loadable_program_memory.sv - BIP instruction memory loaded at run time from a byte stream
//
// Ports:
//   i_clock   in   1   clock, rising edge
//   i_reset   in   1   synchronous, active-high reset
//   bus       slave modport of bip_loadable_program_memory_if (fetch bus, load stream, status)
//
// IDLE waits for i_load_start. LOAD assembles bytes LSB-first into words and writes them
// from address 0 until a HALT (all-zero) word or the last address is written. RUN serves
// registered fetches; a new i_load_start restarts the load.
module bip_loadable_program_memory #(
    parameter int NB_DATA            = 16,
    parameter int N_ADDR             = 2048,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_BYTE            = 8
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    bip_loadable_program_memory_if.slave        bus
);
    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_CNT-1:0]               LAST_LANE  = NB_CNT'(BPW - 1);
    localparam logic [LOG2_N_INSMEM_ADDR-1:0]   LAST_ADDR  = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);
    localparam logic [LOG2_N_INSMEM_ADDR:0]     FULL_COUNT = (LOG2_N_INSMEM_ADDR + 1)'(N_ADDR);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t state, next_state;

    // No reset on the array: contents survive i_reset and rely on the zero (HALT)
    // power-up contents of the RAM.
    logic [NB_DATA-1:0]            mem [N_ADDR];

    logic [NB_DATA-1:0]            word_buf;
    logic [NB_DATA-1:0]            next_word;
    logic [NB_CNT-1:0]             byte_cnt;
    logic [LOG2_N_INSMEM_ADDR-1:0] ptr;
    logic [NB_DATA-1:0]            data_q;
    logic                          program_ready_q;
    logic [LOG2_N_INSMEM_ADDR:0]   load_count_q;
    logic                          overflow_q;

    logic start_load;
    logic accept;
    logic word_done;
    logic word_halt;
    logic word_full;
    logic addr_in_range;

    always_comb begin
        next_word = word_buf;
        next_word[int'(byte_cnt) * NB_BYTE +: NB_BYTE] = bus.i_load_byte;
    end

    // Start is only honoured outside LOAD; a start during a load is ignored.
    assign start_load    = bus.i_load_start && (state != LOAD);
    assign accept        = (state == LOAD) && bus.i_load_valid;
    assign word_done     = accept && (byte_cnt == LAST_LANE);
    assign word_halt     = word_done && (next_word == '0);
    assign word_full     = word_done && !word_halt && (ptr == LAST_ADDR);
    assign addr_in_range = ({1'b0, bus.i_addr} < FULL_COUNT);

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_load) next_state = LOAD;
            LOAD:    if (word_halt || word_full) next_state = RUN;
            RUN:     if (start_load) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (word_done) mem[ptr] <= next_word;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_q          <= '0;
            program_ready_q <= 1'b0;
            load_count_q    <= '0;
            overflow_q      <= 1'b0;
            byte_cnt        <= '0;
            ptr             <= '0;
            word_buf        <= '0;
        end else if (start_load) begin
            data_q          <= '0;
            program_ready_q <= 1'b0;
            load_count_q    <= '0;
            overflow_q      <= 1'b0;
            byte_cnt        <= '0;
            ptr             <= '0;
        end else if (accept) begin
            word_buf <= next_word;
            byte_cnt <= (byte_cnt == LAST_LANE) ? '0 : byte_cnt + 1'b1;
            if (word_done) begin
                ptr <= ptr + 1'b1;
                if (word_halt) begin
                    program_ready_q <= 1'b1;
                    load_count_q    <= {1'b0, ptr} + 1'b1;
                end else if (word_full) begin
                    overflow_q   <= 1'b1;
                    load_count_q <= FULL_COUNT;
                end
            end
        end else if ((state == RUN) && bus.i_enable) begin
            data_q <= addr_in_range ? mem[bus.i_addr] : '0;
        end
    end

    assign bus.o_data          = data_q;
    assign bus.o_load_ready    = (state == LOAD);
    assign bus.o_program_ready = program_ready_q;
    assign bus.o_load_count    = load_count_q;
    assign bus.o_overflow      = overflow_q;
endmodule

// File: tb/tb_bip_loadable_program_memory.sv
// tb/tb_bip_loadable_program_memory.sv - self-checking bench for bip_loadable_program_memory
module tb_bip_loadable_program_memory;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bip_loadable_program_memory_if #(.NB_DATA(16), .LOG2_N_INSMEM_ADDR(11), .NB_BYTE(8)) bus_a ();
    bip_loadable_program_memory_if #(.NB_DATA(16), .LOG2_N_INSMEM_ADDR(2),  .NB_BYTE(8)) bus_b ();

    bip_loadable_program_memory #(
        .NB_DATA(16), .N_ADDR(2048), .LOG2_N_INSMEM_ADDR(11), .NB_BYTE(8)
    ) dut_a (
        .i_clock (clk),
        .i_reset (reset_a),
        .bus     (bus_a)
    );

    bip_loadable_program_memory #(
        .NB_DATA(16), .N_ADDR(4), .LOG2_N_INSMEM_ADDR(2), .NB_BYTE(8)
    ) dut_b (
        .i_clock (clk),
        .i_reset (reset_b),
        .bus     (bus_b)
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  byte_v;
        logic [10:0] addr;
        logic        en;
        logic [15:0] exp_data;
        logic        exp_lrdy;
        logic        exp_prdy;
        logic [11:0] exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [15:0] d, input logic lr,
                           input logic pr, input logic [11:0] cnt, input logic ovf);
        check({tag, " data"},          32'(bus_a.o_data),          32'(d));
        check({tag, " load_ready"},    32'(bus_a.o_load_ready),    32'(lr));
        check({tag, " program_ready"}, 32'(bus_a.o_program_ready), 32'(pr));
        check({tag, " load_count"},    32'(bus_a.o_load_count),    32'(cnt));
        check({tag, " overflow"},      32'(bus_a.o_overflow),      32'(ovf));
    endtask

    task automatic idle_a();
        bus_a.i_load_start = 1'b0;
        bus_a.i_load_valid = 1'b0;
        bus_a.i_load_byte  = 8'h00;
        bus_a.i_enable     = 1'b0;
    endtask

    task automatic byte_a(input logic [7:0] b, input logic start);
        bus_a.i_load_valid = 1'b1;
        bus_a.i_load_byte  = b;
        bus_a.i_load_start = start;
        tick();
        idle_a();
    endtask

    task automatic read_a(input logic [10:0] addr, input logic [15:0] exp, input string tag);
        bus_a.i_addr   = addr;
        bus_a.i_enable = 1'b1;
        tick();
        check(tag, 32'(bus_a.o_data), 32'(exp));
        bus_a.i_enable = 1'b0;
    endtask

    task automatic byte_b(input logic [7:0] b);
        bus_b.i_load_valid = 1'b1;
        bus_b.i_load_byte  = b;
        tick();
        bus_b.i_load_valid = 1'b0;
    endtask

    task automatic read_b(input logic [1:0] addr, input logic [15:0] exp, input string tag);
        bus_b.i_addr   = addr;
        bus_b.i_enable = 1'b1;
        tick();
        check(tag, 32'(bus_b.o_data), 32'(exp));
        bus_b.i_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog_a [6];
        logic [7:0] prog_b [8];
        int gap;

        //            st   vld  byte   addr   en   data      lrdy prdy cnt    ovf
        vecs[0]  = '{1'b0,1'b0,8'h00,11'd0,1'b1,16'h0000,1'b0,1'b0,12'd0,1'b0};
        vecs[1]  = '{1'b1,1'b0,8'h00,11'd0,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};
        vecs[2]  = '{1'b0,1'b1,8'h01,11'd0,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};
        vecs[3]  = '{1'b0,1'b1,8'h08,11'd0,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};
        vecs[4]  = '{1'b0,1'b1,8'h02,11'd0,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};
        vecs[5]  = '{1'b0,1'b1,8'h28,11'd0,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};
        vecs[6]  = '{1'b0,1'b1,8'h00,11'd0,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};
        vecs[7]  = '{1'b0,1'b1,8'h00,11'd0,1'b1,16'h0000,1'b0,1'b1,12'd3,1'b0};
        vecs[8]  = '{1'b0,1'b0,8'h00,11'd1,1'b1,16'h2802,1'b0,1'b1,12'd3,1'b0};
        vecs[9]  = '{1'b0,1'b0,8'h00,11'd0,1'b0,16'h2802,1'b0,1'b1,12'd3,1'b0};
        vecs[10] = '{1'b0,1'b0,8'h00,11'd0,1'b1,16'h0801,1'b0,1'b1,12'd3,1'b0};
        vecs[11] = '{1'b0,1'b0,8'h00,11'd2,1'b1,16'h0000,1'b0,1'b1,12'd3,1'b0};
        vecs[12] = '{1'b0,1'b0,8'h00,11'd1,1'b1,16'h2802,1'b0,1'b1,12'd3,1'b0};
        vecs[13] = '{1'b1,1'b0,8'h00,11'd1,1'b1,16'h0000,1'b1,1'b0,12'd0,1'b0};

        prog_a = '{8'h01, 8'h08, 8'h02, 8'h28, 8'h00, 8'h00};
        prog_b = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'hB0, 8'hA0};

        idle_a();
        bus_a.i_addr = '0;
        bus_b.i_load_start = 1'b0;
        bus_b.i_load_valid = 1'b0;
        bus_b.i_load_byte  = 8'h00;
        bus_b.i_enable     = 1'b0;
        bus_b.i_addr       = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        check_a("reset", 16'h0000, 1'b0, 1'b0, 12'd0, 1'b0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Reset state, back-to-back load, fetches, start-over-fetch priority.
        for (int i = 0; i < 14; i++) begin
            bus_a.i_load_start = vecs[i].start;
            bus_a.i_load_valid = vecs[i].valid;
            bus_a.i_load_byte  = vecs[i].byte_v;
            bus_a.i_addr       = vecs[i].addr;
            bus_a.i_enable     = vecs[i].en;
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_lrdy,
                    vecs[i].exp_prdy, vecs[i].exp_cnt, vecs[i].exp_ovf);
        end
        idle_a();

        // Same program with idle gaps on the stream; junk on i_load_byte while not valid.
        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                bus_a.i_load_byte = 8'($urandom);
                tick();
                check($sformatf("gap b%0d load_ready", i), 32'(bus_a.o_load_ready), 32'd1);
            end
            byte_a(prog_a[i], 1'b0);
        end
        check_a("gapped load", 16'h0000, 1'b0, 1'b1, 12'd3, 1'b0);
        read_a(11'd0, 16'h0801, "gapped mem0");
        read_a(11'd1, 16'h2802, "gapped mem1");
        read_a(11'd2, 16'h0000, "gapped mem2");

        // Reset in the middle of a load, then a complete load.
        bus_a.i_load_start = 1'b1;
        tick();
        idle_a();
        byte_a(8'hAA, 1'b0);
        byte_a(8'hBB, 1'b0);
        byte_a(8'hCC, 1'b0);
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        check_a("midload reset", 16'h0000, 1'b0, 1'b0, 12'd0, 1'b0);
        read_a(11'd0, 16'h0000, "idle fetch ignored");
        bus_a.i_load_start = 1'b1;
        tick();
        idle_a();
        byte_a(8'h34, 1'b0);
        byte_a(8'h12, 1'b0);
        byte_a(8'h78, 1'b1);
        byte_a(8'h56, 1'b0);
        byte_a(8'h00, 1'b0);
        check("reload before halt program_ready", 32'(bus_a.o_program_ready), 32'd0);
        byte_a(8'h00, 1'b0);
        check_a("reload", 16'h0000, 1'b0, 1'b1, 12'd3, 1'b0);
        read_a(11'd0, 16'h1234, "reload mem0");
        read_a(11'd1, 16'h5678, "reload mem1");
        read_a(11'd2, 16'h0000, "reload mem2");
        read_a(11'd1, 16'h5678, "pre-restart fetch");
        bus_a.i_addr       = 11'd1;
        bus_a.i_enable     = 1'b1;
        bus_a.i_load_start = 1'b1;
        tick();
        idle_a();
        check_a("restart in run", 16'h0000, 1'b1, 1'b0, 12'd0, 1'b0);

        // Four-word memory filled without a HALT word.
        bus_b.i_load_start = 1'b1;
        tick();
        bus_b.i_load_start = 1'b0;
        for (int i = 0; i < 7; i++) byte_b(prog_b[i]);
        check("full pre-last overflow", 32'(bus_b.o_overflow), 32'd0);
        check("full pre-last load_ready", 32'(bus_b.o_load_ready), 32'd1);
        byte_b(prog_b[7]);
        check("full overflow", 32'(bus_b.o_overflow), 32'd1);
        check("full load_count", 32'(bus_b.o_load_count), 32'd4);
        check("full load_ready", 32'(bus_b.o_load_ready), 32'd0);
        byte_b(8'h55);
        check("full extra byte load_ready", 32'(bus_b.o_load_ready), 32'd0);
        check("full overflow held", 32'(bus_b.o_overflow), 32'd1);
        read_b(2'd0, 16'h0102, "full mem0");
        read_b(2'd1, 16'h0304, "full mem1");
        read_b(2'd2, 16'h0506, "full mem2");
        read_b(2'd3, 16'hA0B0, "full mem3");
        bus_b.i_load_start = 1'b1;
        tick();
        bus_b.i_load_start = 1'b0;
        check("restart overflow cleared", 32'(bus_b.o_overflow), 32'd0);
        check("restart count cleared", 32'(bus_b.o_load_count), 32'd0);
        byte_b(8'h00);
        byte_b(8'h00);
        check("halt-only load_count", 32'(bus_b.o_load_count), 32'd1);
        check("halt-only program_ready", 32'(bus_b.o_program_ready), 32'd1);
        check("halt-only overflow", 32'(bus_b.o_overflow), 32'd0);
        read_b(2'd1, 16'h0304, "halt-only mem1 kept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
